// File: rtl/sha256_round_engine.sv
// SHA-256 compression engine: RPS rounds per step, optional mid-step register,
// start/ready/done handshake with multi-block chaining and abort.

module sha256_rnd (
  input  logic [2:0][31:0] abc,
  input  logic [3:0][31:0] efgh,
  input  logic [31:0]      kw,
  output logic [31:0]      t1,
  output logic [31:0]      t2
);
  logic [31:0] a, b, c, e, f, g, h, s0, s1;

  assign {a, b, c}    = abc;
  assign {e, f, g, h} = efgh;
  assign s0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
  assign s1 = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
  assign t1 = h + s1 + ((e & f) ^ (~e & g)) + kw;
  assign t2 = s0 + ((a & b) ^ (a & c) ^ (b & c));
endmodule

module sha256_round_engine #(
  parameter int RPS  = 2,
  parameter int PIPE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              first_blk,
  input  logic              abort,
  input  logic [32*RPS-1:0] w_in,
  input  logic [32*RPS-1:0] k_in,
  output logic [5:0]        round_idx,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic [255:0]      hash_val
);
  if (!(RPS == 1 || RPS == 2 || RPS == 4)) begin : g_bad_rps
    $error("sha256_round_engine: RPS must be 1, 2 or 4");
  end

  typedef logic [7:0][31:0] st_t;  // [7]=a/H0 ... [0]=h/H7
  typedef enum logic [1:0] {IDLE, LOAD, ROUND, FINAL} state_t;

  localparam st_t IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [5:0] STEP = 6'(RPS);
  localparam logic [5:0] LAST = 6'(64 - RPS);

  state_t state;
  st_t    wk, hc, hv, step_nxt;
  logic   cyc;

  // With PIPE, lane 0 folds its T1/T2 into registers in the first step cycle;
  // later lanes only need their W+K held, since their inputs come from lane 0.
  for (genvar j = 0; j < RPS; j++) begin : g_lane
    st_t         cur, nxt;
    logic [31:0] kw_live, kw_use, t1, t2, t1_e, t2_e;

    if (j == 0) begin : g_head
      assign cur = wk;
    end else begin : g_chain
      assign cur = g_lane[j-1].nxt;
    end

    assign kw_live = w_in[32*j +: 32] + k_in[32*j +: 32];

    sha256_rnd u_rnd (.abc(cur[7:5]), .efgh(cur[3:0]), .kw(kw_use), .t1(t1), .t2(t2));

    if (PIPE == 0) begin : g_comb
      assign kw_use = kw_live;
      assign t1_e   = t1;
      assign t2_e   = t2;
    end else if (j == 0) begin : g_stage
      logic [31:0] p_t1, p_t2;
      always_ff @(posedge clk or negedge rst)
        if (!rst) begin
          p_t1 <= '0;
          p_t2 <= '0;
        end else if (state == ROUND && !cyc) begin
          p_t1 <= t1;
          p_t2 <= t2;
        end
      assign kw_use = kw_live;
      assign t1_e   = p_t1;
      assign t2_e   = p_t2;
    end else begin : g_hold
      logic [31:0] p_kw;
      always_ff @(posedge clk or negedge rst)
        if (!rst)                        p_kw <= '0;
        else if (state == ROUND && !cyc) p_kw <= kw_live;
      assign kw_use = p_kw;
      assign t1_e   = t1;
      assign t2_e   = t2;
    end

    assign nxt = {t1_e + t2_e, cur[7:5], cur[4] + t1_e, cur[3:1]};
  end

  assign step_nxt = g_lane[RPS-1].nxt;
  assign hash_val = hv;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      wk        <= '0;
      hc        <= '0;
      hv        <= '0;
      cyc       <= 1'b0;
      round_idx <= '0;
      ready     <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        cyc       <= 1'b0;
        round_idx <= '0;
        ready     <= 1'b1;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            hc    <= first_blk ? IV : hv;
            state <= LOAD;
            ready <= 1'b0;
            busy  <= 1'b1;
          end
          LOAD: begin
            wk        <= hc;
            round_idx <= '0;
            cyc       <= 1'b0;
            state     <= ROUND;
          end
          ROUND: if (PIPE != 0 && !cyc) begin
            cyc <= 1'b1;
          end else begin
            cyc       <= 1'b0;
            wk        <= step_nxt;
            round_idx <= round_idx + STEP;  // wraps to 0 after the last step
            if (round_idx == LAST) state <= FINAL;
          end
          FINAL: begin
            for (int i = 0; i < 8; i++) hv[i] <= hc[i] + wk[i];
            done  <= 1'b1;
            ready <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
